rcu_clk_div_bank: RTL and testbench
===================================

Name: rcu_clk_div_bank

Overview:
- Parametrised bank of CH_NUM independent integer clock dividers for the reset/clock control unit.
- Generalises the fixed single-ratio divider:
  - per-channel runtime divide ratio and enable;
  - glitch-free ratio switching at period boundaries;
  - per-channel done/busy status.
- Sits between the control register file and the clock muxes.
- Produces a divided clock and a one-cycle trigger per channel, all from one source clock.

Parameters:
- CH_NUM, 4, number of divider channels (1..16).
- DIV_WIDTH, 8, width of the divide value; period = D+1 source cycles.
- DONE_DELAY, 3, cycles from a config taking effect to its done_o pulse (1..15).

Ports:
- clk_i  in  1  source clock; all logic on its rising edge.
- rst_i  in  1  asynchronous active-high reset.
- cfg_valid_i  in  1  config request valid.
- cfg_ready_o  out  1  config request accepted when high together with cfg_valid_i.
- cfg_ch_i  in  $clog2(CH_NUM) (min 1)  target channel.
- cfg_en_i  in  1  1 = run channel, 0 = stop channel.
- cfg_div_i  in  DIV_WIDTH  divide value D.
- trg_o  out  CH_NUM  one-cycle pulse in the last cycle of each period.
- clk_o  out  CH_NUM  registered divided clock.
- done_o  out  CH_NUM  one-cycle pulse DONE_DELAY cycles after a config takes effect.
- busy_o  out  CH_NUM  high while a config is pending or settling.

Behaviour:
- Reset (async, rst_i=1):
  - all channels in IDLE, cnt=0, div=0;
  - trg_o, clk_o, done_o and busy_o all 0; cfg_ready_o=1.
- Per-channel state:
  - IDLE: stopped; outputs 0.
  - RUN: counting.
  - PEND: new config latched, waiting for the period boundary.
  - SETTLE: DONE_DELAY countdown.
- Handshake:
  - cfg_ready_o = addressed channel is in IDLE or RUN (combinational on cfg_ch_i).
  - A transfer occurs on cfg_valid_i & cfg_ready_o at the rising edge.
  - A request to a busy channel stalls, is not dropped, and does not block other channels' progress.
  - An out-of-range cfg_ch_i (≥CH_NUM) gives cfg_ready_o=1; the request is accepted and ignored.
- IDLE + accept with en=1:
  - latch D; next cycle cnt=0 and state SETTLE (config effective immediately).
- IDLE + accept with en=0:
  - no change except SETTLE entry, so done_o still pulses.
- RUN + accept:
  - latch {en, D} into pending registers and go to PEND.
  - The current period completes with the old D.
  - In the cycle where cnt==old D (trg_o=1), the pending config is applied: cnt←0 and div←new D, or channel→IDLE if en=0. State goes to SETTLE.
- SETTLE:
  - channel counts normally with the new config, or stays stopped if disabled;
  - after DONE_DELAY cycles done_o pulses for one cycle;
  - state returns to RUN, or IDLE if disabled.
- busy_o = state ∈ {PEND, SETTLE}.
- Counter and outputs:
  - cnt counts 0..D and wraps to 0.
  - trg_o = running & (cnt==D).
  - clk_o registered: high while cnt < ((D+1)>>1), else low.
  - Even D+1 gives 50% duty; odd D+1 gives low phase one cycle longer.
- Boundary cases:
  - D=0: trg_o constantly 1 while running; clk_o constantly 0.
  - D=max: period 2^DIV_WIDTH with no overflow. Compare width is DIV_WIDTH+1 for (D+1)>>1.
- Disable: clk_o and trg_o go 0 the cycle after the final period's trg_o pulse; never a truncated high phase.
- Reset mid-operation: immediate return to the reset state; pending configs are discarded; no done_o pulse.
- Simultaneous events:
  - Config acceptance and the wrap on the same channel in the same cycle: the config is latched to pending and applied at the NEXT boundary.
  - Each channel is fully independent; done_o pulses on several channels in the same cycle are allowed.

Optional Feature:
- Macro RCU_CLKDIV_SYNC_EN adds input sync_i (1 bit).
- When defined: sync_i=1 forces cnt←0 next cycle on every channel in RUN or SETTLE, aligning phases.
  - clk_o on those channels restarts at its high phase.
  - No trg_o pulse is generated by the sync itself.
  - Channels in PEND apply their pending config at this forced boundary, entering SETTLE.
- When undefined: port absent; behaviour as above.

Test Plan:
- Reset, then cfg ch0 en=1 D=3 → cfg_ready_o=1 throughout. Afterwards:
  - trg_o[0] every 4 cycles;
  - clk_o[0] 2 high / 2 low;
  - done_o[0] pulse 3 cycles after the config takes effect.
- ch1 running D=4, reconfig to D=1 mid-period → old 5-cycle period completes, then 2-cycle periods. Status:
  - busy_o[1]=1 from accept to done;
  - a second request to ch1 while busy sees cfg_ready_o=0 and stalls until done.
- ch2 D=0 → trg_o[2] constantly 1 and clk_o[2] constantly 0. Then ch2 D=255 → period 256, clk_o high 128 cycles.
- ch0 running D=2, disable → clk_o[0] and trg_o[0] go 0 only after the current period's trg_o; done_o[0] pulses; state IDLE.
- Reset asserted mid-SETTLE on ch3 → all outputs 0 asynchronously; no done_o after release; cfg_ready_o=1.
- With RCU_CLKDIV_SYNC_EN: ch0 D=3 and ch1 D=5 running at different phases, pulse sync_i → both cnt=0 the next cycle; clk_o rising edges aligned.

Source files
------------

// File: rtl/rcu_clk_div_bank.sv
// rcu_clk_div_bank: a bank of CH_NUM independent integer clock dividers.
// Each channel's divide ratio and enable are set at runtime through one shared
// config port. A new ratio takes effect only at a period boundary, so the
// divided clock never has a truncated phase. Period = D+1 source cycles.
// Optional build macro: RCU_CLKDIV_SYNC_EN adds sync_i, which restarts every
// running channel at cnt=0 so that their phases line up.
module rcu_clk_div_bank #(
  parameter int CH_NUM     = 4,
  parameter int DIV_WIDTH  = 8,
  parameter int DONE_DELAY = 3,
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CH_W-1:0]      cfg_ch_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
`ifdef RCU_CLKDIV_SYNC_EN
  input  logic                 sync_i,
`endif
  output logic [CH_NUM-1:0]    trg_o,
  output logic [CH_NUM-1:0]    clk_o,
  output logic [CH_NUM-1:0]    done_o,
  output logic [CH_NUM-1:0]    busy_o
);

  // Config handshake: a transfer happens on the rising edge where
  // cfg_valid_i && cfg_ready_o. cfg_ready_o depends combinationally on
  // cfg_ch_i and is high when the addressed channel is IDLE or RUN. An
  // out-of-range channel is always ready, and its request is dropped.
  // The requester holds valid and data stable until the transfer.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PEND   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  localparam int           SLOTS       = 1 << CH_W;
  localparam logic [3:0]   SETTLE_LOAD = 4'(DONE_DELAY - 1);

  logic [SLOTS-1:0] w_slot_ready;
  logic             w_sync;

`ifdef RCU_CLKDIV_SYNC_EN
  assign w_sync = sync_i;
`else
  assign w_sync = 1'b0;
`endif

  assign cfg_ready_o = w_slot_ready[cfg_ch_i];

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_ch
    if (gi < CH_NUM) begin : g_live
      state_t               r_state, w_state_nxt;
      logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nxt;
      logic [DIV_WIDTH-1:0] r_div, w_div_nxt;
      logic [DIV_WIDTH-1:0] r_pend_div, w_pend_div_nxt;
      logic                 r_pend_en, w_pend_en_nxt;
      logic                 r_run, w_run_nxt;
      logic [3:0]           r_settle, w_settle_nxt;
      logic                 r_clk, r_done, w_done_nxt;
      logic                 w_acc, w_wrap;
      logic [DIV_WIDTH:0]   w_half_nxt;

      assign w_acc  = cfg_valid_i & (cfg_ch_i == CH_W'(gi)) & w_slot_ready[gi];
      assign w_wrap = r_run & (r_cnt == r_div);
      // The extra bit keeps (D+1)>>1 exact when D is at its maximum value
      assign w_half_nxt = ({1'b0, w_div_nxt} + {{DIV_WIDTH{1'b0}}, 1'b1}) >> 1;

      // Next state: counter step, then phase sync, then the config FSM
      always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_div_nxt      = r_div;
        w_run_nxt      = r_run;
        w_pend_en_nxt  = r_pend_en;
        w_pend_div_nxt = r_pend_div;
        w_settle_nxt   = r_settle;
        w_done_nxt     = 1'b0;
        if (r_run) w_cnt_nxt = w_wrap ? '0 : r_cnt + DIV_WIDTH'(1);
        if (w_sync && r_run) w_cnt_nxt = '0;
        unique case (r_state)
          S_IDLE: begin
            if (w_acc) begin
              if (cfg_en_i) w_div_nxt = cfg_div_i;
              w_run_nxt    = cfg_en_i;
              w_cnt_nxt    = '0;
              w_settle_nxt = SETTLE_LOAD;
              w_state_nxt  = S_SETTLE;
            end
          end
          S_RUN: begin
            if (w_acc) begin
              w_pend_en_nxt  = cfg_en_i;
              w_pend_div_nxt = cfg_div_i;
              w_state_nxt    = S_PEND;
            end
          end
          S_PEND: begin
            // Apply at the natural boundary (trg cycle) or a forced sync boundary
            if (w_wrap || w_sync) begin
              w_cnt_nxt    = '0;
              w_run_nxt    = r_pend_en;
              if (r_pend_en) w_div_nxt = r_pend_div;
              w_settle_nxt = SETTLE_LOAD;
              w_state_nxt  = S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_settle == 4'd0) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = r_run ? S_RUN : S_IDLE;
            end else begin
              w_settle_nxt = r_settle - 4'd1;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end

      // Channel state registers; the divided clock follows the next count
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_div      <= '0;
          r_pend_div <= '0;
          r_pend_en  <= 1'b0;
          r_run      <= 1'b0;
          r_settle   <= '0;
          r_clk      <= 1'b0;
          r_done     <= 1'b0;
        end else begin
          r_state    <= w_state_nxt;
          r_cnt      <= w_cnt_nxt;
          r_div      <= w_div_nxt;
          r_pend_div <= w_pend_div_nxt;
          r_pend_en  <= w_pend_en_nxt;
          r_run      <= w_run_nxt;
          r_settle   <= w_settle_nxt;
          r_clk      <= w_run_nxt & ({1'b0, w_cnt_nxt} < w_half_nxt);
          r_done     <= w_done_nxt;
        end
      end

      assign trg_o[gi]        = w_wrap;
      assign clk_o[gi]        = r_clk;
      assign done_o[gi]       = r_done;
      assign busy_o[gi]       = (r_state == S_PEND) | (r_state == S_SETTLE);
      assign w_slot_ready[gi] = (r_state == S_IDLE) | (r_state == S_RUN);
    end else begin : g_absent
      assign w_slot_ready[gi] = 1'b1;
    end
  end

endmodule

// File: tb/tb_rcu_clk_div_bank.sv
// Testbench for rcu_clk_div_bank (CH_NUM=4, DIV_WIDTH=8, DONE_DELAY=3).
// Expected per-cycle {trg, clk, done, busy} are pushed to exp_q from the
// intended timeline, then popped and compared once per cycle.
`timescale 1ns/1ps
module tb_rcu_clk_div_bank;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic       cfg_en;
  logic [7:0] cfg_div;
  logic [3:0] trg, clk_div, done, busy;
`ifdef RCU_CLKDIV_SYNC_EN
  logic       sync;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rcu_clk_div_bank #(.CH_NUM(4), .DIV_WIDTH(8), .DONE_DELAY(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_ch_i    (cfg_ch),
    .cfg_en_i    (cfg_en),
    .cfg_div_i   (cfg_div),
`ifdef RCU_CLKDIV_SYNC_EN
    .sync_i      (sync),
`endif
    .trg_o       (trg),
    .clk_o       (clk_div),
    .done_o      (done),
    .busy_o      (busy)
  );

  // ---------------- helpers / drivers ----------------
  function automatic logic [3:0] exp_bits(bit run, int cnt, int d, bit dn, bit bz);
    logic t, k;
    t = run && (cnt == d);
    k = run && (cnt < (d + 1) / 2);
    return {t, k, dn, bz};
  endfunction

  function automatic logic [3:0] obs_bits(int ch);
    return {trg[ch], clk_div[ch], done[ch], busy[ch]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_en = 1'b0;
    cfg_div = '0;
`ifdef RCU_CLKDIV_SYNC_EN
    sync = 1'b0;
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  // One-cycle request; returns the ready seen before the edge
  task automatic drive_cfg(input int ch, input bit en, input int dv, output logic rdy);
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_en = en;
    cfg_div = 8'(dv);
    #1 rdy = cfg_ready;
    tick();
    cfg_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({trg, clk_div, done, busy} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0000", {trg, clk_div, done, busy});
    end
    for (int ch = 0; ch < 4; ch++) begin
      cfg_ch = 2'(ch);
      #1;
      n_tests++;
      if (cfg_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready ch=%0d got=%b exp=1", ch, cfg_ready);
      end
    end
    tick();
  endtask

  task automatic test_basic();
    logic rdy;
    logic [7:0] e, g;
    do_reset();
    repeat ($urandom_range(0, 3)) tick();
    drive_cfg(0, 1'b1, 3, rdy);
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready got=%b exp=1", rdy);
    end
    for (int c = 0; c < 16; c++)
      exp_q.push_back({4'h0, exp_bits(1'b1, c % 4, 3, c == 3, c < 3)});
    for (int c = 0; c < 16; c++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      g = {4'h0, obs_bits(0)};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL basic c=%0d got=%b exp=%b", c, g[3:0], e[3:0]);
      end
      tick();
    end
  endtask

  task automatic test_reconfig();
    logic rdy;
    logic [7:0] e, g;
    int stall, acc_c, d, cnt;
    do_reset();
    drive_cfg(1, 1'b1, 4, rdy);
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reconf_ready0 got=%b exp=1", rdy);
    end
    for (int c = 0; c < 28; c++) begin
      if (c < 10) begin d = 4; cnt = c % 5; end
      else if (c < 16) begin d = 1; cnt = (c - 10) % 2; end
      else begin d = 2; cnt = (c - 16) % 3; end
      exp_q.push_back({4'h0, exp_bits(1'b1, cnt, d, (c == 3) || (c == 13) || (c == 19),
                       (c < 3) || (c >= 8 && c <= 12) || (c >= 14 && c <= 18))});
    end
    stall = 0;
    acc_c = -1;
    for (int c = 0; c < 28; c++) begin
      if (c == 7) begin
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_en = 1'b1; cfg_div = 8'd1;
      end
      if (c == 8) cfg_div = 8'd2;
      #1;
      if (c == 7) begin
        n_tests++;
        if (cfg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL reconf_ready1 got=%b exp=1", cfg_ready);
        end
      end else if (c >= 8 && cfg_valid) begin
        if (cfg_ready === 1'b1) acc_c = c;
        else stall++;
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      g = {4'h0, obs_bits(1)};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reconf c=%0d got=%b exp=%b", c, g[3:0], e[3:0]);
      end
      @(posedge clk);
      #1;
      if (acc_c >= 0) cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;
    n_tests++;
    if (stall != 5 || acc_c != 13) begin
      n_fail++;
      $display("FAIL reconf_stall stall=%0d acc=%0d exp stall=5 acc=13", stall, acc_c);
    end
  endtask

  task automatic test_d0_dmax();
    logic rdy;
    logic [7:0] e, g;
    do_reset();
    drive_cfg(2, 1'b1, 0, rdy);
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL d0_ready got=%b exp=1", rdy);
    end
    for (int c = 0; c < 276; c++) begin
      if (c <= 11) exp_q.push_back({4'h0, exp_bits(1'b1, 0, 0, c == 3, (c < 3) || (c == 11))});
      else exp_q.push_back({4'h0, exp_bits(1'b1, (c - 12) % 256, 255, c == 15, c <= 14)});
    end
    for (int c = 0; c < 276; c++) begin
      if (c == 10) begin
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_en = 1'b1; cfg_div = 8'd255;
      end
      if (c == 11) cfg_valid = 1'b0;
      #1;
      if (c == 10) begin
        n_tests++;
        if (cfg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL dmax_ready got=%b exp=1", cfg_ready);
        end
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      g = {4'h0, obs_bits(2)};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL d0_dmax c=%0d got=%b exp=%b", c, g[3:0], e[3:0]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_disable();
    logic rdy;
    logic [7:0] e, g;
    do_reset();
    drive_cfg(0, 1'b1, 2, rdy);
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL dis_ready0 got=%b exp=1", rdy);
    end
    for (int c = 0; c < 22; c++) begin
      if (c <= 8) exp_q.push_back({4'h0, exp_bits(1'b1, c % 3, 2, c == 3, (c < 3) || (c == 8))});
      else if (c <= 17) exp_q.push_back({4'h0, exp_bits(1'b0, 0, 0, c == 12, c <= 11)});
      else exp_q.push_back({4'h0, exp_bits(1'b1, c - 18, 3, c == 21, c < 21)});
    end
    for (int c = 0; c < 22; c++) begin
      if (c == 7) begin
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_en = 1'b0; cfg_div = 8'd0;
      end
      if (c == 17) begin
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_en = 1'b1; cfg_div = 8'd3;
      end
      if (c == 8 || c == 18) cfg_valid = 1'b0;
      #1;
      if (c == 7 || c == 17) begin
        n_tests++;
        if (cfg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL dis_ready c=%0d got=%b exp=1", c, cfg_ready);
        end
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      g = {4'h0, obs_bits(0)};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL disable c=%0d got=%b exp=%b", c, g[3:0], e[3:0]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_settle();
    logic rdy;
    logic [7:0] e, g;
    do_reset();
    drive_cfg(3, 1'b1, 5, rdy);
    tick();
    n_tests++;
    if (busy[3] !== 1'b1 || clk_div[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL settle_pre busy=%b clk=%b exp busy=1 clk=1", busy[3], clk_div[3]);
    end
    #2 rst = 1'b1;
    cfg_ch = 2'd3;
    #1;
    n_tests++;
    if ({trg, clk_div, done, busy} !== 16'h0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset outs=%h ready=%b exp outs=0000 ready=1",
               {trg, clk_div, done, busy}, cfg_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 12; c++) exp_q.push_back(8'h00);
    for (int c = 0; c < 12; c++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      g = {done, obs_bits(3)};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL post_reset c=%0d got=%b exp=%b", c, g, e);
      end
      tick();
    end
  endtask

`ifdef RCU_CLKDIV_SYNC_EN
  task automatic test_sync();
    logic rdy0, rdy1;
    logic [7:0] e, g;
    int c0, c1;
    do_reset();
    drive_cfg(0, 1'b1, 3, rdy0);
    drive_cfg(1, 1'b1, 5, rdy1);
    n_tests++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_ready got=%b%b exp=11", rdy0, rdy1);
    end
    for (int c = 1; c <= 30; c++) begin
      c0 = (c < 11) ? c % 4 : (c - 11) % 4;
      c1 = (c < 11) ? (c - 1) % 6 : (c - 11) % 6;
      exp_q.push_back({exp_bits(1'b1, c1, 5, c == 4, c < 4), exp_bits(1'b1, c0, 3, c == 3, c < 3)});
    end
    for (int c = 1; c <= 30; c++) begin
      sync = (c == 10);
      #1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      g = {obs_bits(1), obs_bits(0)};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL sync c=%0d got=%b exp=%b", c, g, e);
      end
      @(posedge clk);
      #1;
    end
    sync = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_reconfig();
    test_d0_dmax();
    test_disable();
    test_reset_mid_settle();
`ifdef RCU_CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
